// File: rtl/elevator_pkg.sv
// Shared elevator definitions: controller status codes and default floor geometry.
package elevator_pkg;

  localparam int DEF_N_FLOORS = 8;
  localparam int DEF_FLOOR_W  = 3;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    MOVE_UP   = 4'd1,
    MOVE_DOWN = 4'd2,
    OPEN_UP   = 4'd3,
    OPEN_DOWN = 4'd4,
    OPEN_IDLE = 4'd5,
    CLOSING   = 4'd6,
    OFF       = 4'd7
  } status_e;

endpackage

// File: rtl/call_request_latch_if.sv
// Button/request bundle between the board, the request latch and the controller FSM.
interface call_request_latch_if
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = DEF_FLOOR_W
) ();

  logic                power;
  logic [N_FLOORS-1:0] upcall_raw;
  logic [N_FLOORS-1:0] downcall_raw;
  logic [N_FLOORS-1:0] floor_btn_raw;
  logic [FLOOR_W-1:0]  floor;
  logic [3:0]          status;
  logic [N_FLOORS-1:0] upcall;
  logic [N_FLOORS-1:0] downcall;
  logic [N_FLOORS-1:0] floor_btn;
  logic [N_FLOORS-1:0] led;
  logic                req_above;
  logic                req_below;
  logic                req_here;

  modport slave (
    input  power, upcall_raw, downcall_raw, floor_btn_raw, floor, status,
    output upcall, downcall, floor_btn, led, req_above, req_below, req_here
  );

  modport master (
    output power, upcall_raw, downcall_raw, floor_btn_raw, floor, status,
    input  upcall, downcall, floor_btn, led, req_above, req_below, req_here
  );

endinterface

// File: rtl/call_request_latch_btn_edge_sync.sv
// Multi-flop synchronizer plus rising-edge detector for a vector of raw buttons.
module btn_edge_sync #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] pulse
);

  logic [W-1:0]         sync_q [SYNC_STAGES];
  logic [W-1:0]         sync_d [SYNC_STAGES];
  logic [W-1:0]         hist_q, hist_d;
  logic [SYNC_STAGES:0] arm_q, arm_d;

  // NOTE: every _d gets its value on every path so no latch is inferred.
  always_comb begin
    sync_d[0] = raw;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    hist_d = sync_q[SYNC_STAGES-1];
    arm_d  = {arm_q[SYNC_STAGES-1:0], 1'b1};
  end

  // NOTE: sequential state uses <= only, so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      arm_q  <= arm_d;
    end
  end

  // Presses are blanked until the chain refills after reset, so a held button cannot re-arm.
  assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q & {W{arm_q[SYNC_STAGES]}};

endmodule

// File: rtl/call_request_latch.sv
// Latches hall/cabin button presses into pending-request vectors, cleared as floors are served.
// Optional: define CALL_CANCEL_EN to let a repeat cabin press cancel that request.
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  call_request_latch_if.slave bus
);

  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] up_press, dn_press, fb_press;
  logic [N_FLOORS-1:0] upcall_q, upcall_d;
  logic [N_FLOORS-1:0] downcall_q, downcall_d;
  logic [N_FLOORS-1:0] floor_btn_q, floor_btn_d;
  logic [N_FLOORS-1:0] here_vec, above_vec, below_vec, pending;
  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_fb, cancel_fb;
  logic                floor_ok;

  btn_edge_sync #(.W(N_FLOORS), .SYNC_STAGES(SYNC_STAGES)) u_up_sync (
    .clk(clk), .rst(rst), .raw(bus.upcall_raw), .pulse(up_press)
  );
  btn_edge_sync #(.W(N_FLOORS), .SYNC_STAGES(SYNC_STAGES)) u_dn_sync (
    .clk(clk), .rst(rst), .raw(bus.downcall_raw), .pulse(dn_press)
  );
  btn_edge_sync #(.W(N_FLOORS), .SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(clk), .rst(rst), .raw(bus.floor_btn_raw), .pulse(fb_press)
  );

  always_comb begin
    floor_ok = int'(bus.floor) < N_FLOORS;
    for (int i = 0; i < N_FLOORS; i++) begin
      here_vec[i]  = floor_ok && (i == int'(bus.floor));
      above_vec[i] = floor_ok && (i >  int'(bus.floor));
      below_vec[i] = floor_ok && (i <  int'(bus.floor));
    end
  end

  // Clears only fire on OPEN codes; unknown codes fall through to no clear.
  always_comb begin
    clr_up = '0;
    clr_dn = '0;
    clr_fb = '0;
    case (bus.status)
      OPEN_UP:   begin clr_fb = here_vec; clr_up = here_vec; end
      OPEN_DOWN: begin clr_fb = here_vec; clr_dn = here_vec; end
      OPEN_IDLE: begin clr_fb = here_vec; clr_up = here_vec; clr_dn = here_vec; end
      default:   ;
    endcase
  end

`ifdef CALL_CANCEL_EN
  assign cancel_fb = fb_press & floor_btn_q & ~here_vec;
`else
  assign cancel_fb = '0;
`endif

  always_comb begin
    upcall_d    = ((upcall_q | up_press) & UP_MASK) & ~clr_up;
    downcall_d  = ((downcall_q | dn_press) & DN_MASK) & ~clr_dn;
    floor_btn_d = ((floor_btn_q | fb_press) & ~cancel_fb) & ~clr_fb;
    if (!bus.power) begin
      upcall_d    = '0;
      downcall_d  = '0;
      floor_btn_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      upcall_q    <= '0;
      downcall_q  <= '0;
      floor_btn_q <= '0;
    end else begin
      upcall_q    <= upcall_d;
      downcall_q  <= downcall_d;
      floor_btn_q <= floor_btn_d;
    end
  end

  assign pending       = upcall_q | downcall_q | floor_btn_q;
  assign bus.upcall    = upcall_q;
  assign bus.downcall  = downcall_q;
  assign bus.floor_btn = floor_btn_q;
  assign bus.led       = floor_btn_q;
  assign bus.req_above = |(pending & above_vec);
  assign bus.req_below = |(pending & below_vec);
  assign bus.req_here  = |(pending & here_vec);

endmodule

// File: tb/tb_call_request_latch.sv
// Directed self-checking bench for call_request_latch at default geometry.
module tb_call_request_latch;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  call_request_latch_if #(.N_FLOORS(8), .FLOOR_W(3)) bus ();

  call_request_latch #(.N_FLOORS(8), .FLOOR_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Drive one-cycle presses, then wait until the third edge has latched them.
  task automatic press(input logic [7:0] up, input logic [7:0] dn, input logic [7:0] fb);
    bus.upcall_raw    = up;
    bus.downcall_raw  = dn;
    bus.floor_btn_raw = fb;
    tick(1);
    bus.upcall_raw    = '0;
    bus.downcall_raw  = '0;
    bus.floor_btn_raw = '0;
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    bus.power         = 1'b1;
    bus.upcall_raw    = 8'hFF;
    bus.downcall_raw  = 8'hFF;
    bus.floor_btn_raw = 8'hFF;
    bus.floor         = 3'd0;
    bus.status        = 4'(IDLE);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_upcall",    bus.upcall, 8'h00);
    check("rst_downcall",  bus.downcall, 8'h00);
    check("rst_floor_btn", bus.floor_btn, 8'h00);
    tick(6);
    check("held_upcall",    bus.upcall, 8'h00);
    check("held_downcall",  bus.downcall, 8'h00);
    check("held_floor_btn", bus.floor_btn, 8'h00);
    check("held_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'h00);

    bus.upcall_raw    = '0;
    bus.downcall_raw  = '0;
    bus.floor_btn_raw = '0;
    tick(4);

    // Latency: 1-cycle pulse on cabin button 5 at floor 2.
    bus.floor  = 3'd2;
    bus.status = 4'(MOVE_UP);
    bus.floor_btn_raw = 8'h20;
    tick(1);
    bus.floor_btn_raw = '0;
    tick(1);
    check("lat_edge2", bus.floor_btn, 8'h00);
    tick(1);
    check("lat_edge3", bus.floor_btn, 8'h20);
    check("lat_led", bus.led, 8'h20);
    check("lat_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'b100);
    tick(3);
    check("lat_hold", bus.floor_btn, 8'h20);

    // Directional clears at floor 4.
    bus.floor = 3'd4;
    press(8'h10, 8'h10, 8'h00);
    check("dir_set_up", bus.upcall, 8'h10);
    check("dir_set_dn", bus.downcall, 8'h10);
    check("dir_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'b101);
    bus.status = 4'(OPEN_UP);
    tick(1);
    bus.status = 4'(IDLE);
    check("open_up_up", bus.upcall, 8'h00);
    check("open_up_dn", bus.downcall, 8'h10);
    check("open_up_fb", bus.floor_btn, 8'h20);
    bus.status = 4'(OPEN_DOWN);
    tick(1);
    bus.status = 4'(IDLE);
    check("open_dn_dn", bus.downcall, 8'h00);

    // Set and clear in the same cycle at floor 3.
    bus.floor  = 3'd3;
    bus.status = 4'(OPEN_IDLE);
    press(8'h00, 8'h00, 8'h48);
    tick(1);
    bus.status = 4'(IDLE);
    check("simul_fb", bus.floor_btn, 8'h60);
    check("simul_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'b100);

    // Boundary bits: up at top floor and down at ground floor are ignored.
    press(8'h82, 8'h41, 8'h00);
    check("bound_up", bus.upcall, 8'h02);
    check("bound_dn", bus.downcall, 8'h40);
    bus.floor = 3'd7;
    tick(1);
    check("top_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'b010);

    bus.power = 1'b0;
    tick(1);
    bus.power = 1'b1;
    check("pwr_up", bus.upcall, 8'h00);
    check("pwr_dn", bus.downcall, 8'h00);
    check("pwr_fb", bus.floor_btn, 8'h00);

    // Unlisted status code performs no clear.
    bus.floor  = 3'd1;
    bus.status = 4'hC;
    press(8'h00, 8'h00, 8'h02);
    tick(1);
    check("bad_status_fb", bus.floor_btn, 8'h02);
    check("bad_status_flags", {5'b0, bus.req_above, bus.req_below, bus.req_here}, 8'b001);
    bus.status = 4'(IDLE);

    // Button held across power-on yields no press.
    bus.power = 1'b0;
    bus.floor_btn_raw = 8'h80;
    tick(4);
    check("pwr_off_fb", bus.floor_btn, 8'h00);
    bus.power = 1'b1;
    tick(4);
    check("pwr_on_held", bus.floor_btn, 8'h00);
    bus.floor_btn_raw = '0;
    tick(3);

    // Mid-operation reset with a held button.
    press(8'h00, 8'h00, 8'h02);
    check("pre_rst_fb", bus.floor_btn, 8'h02);
    bus.floor_btn_raw = 8'h01;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(6);
    check("mid_rst_fb", bus.floor_btn, 8'h00);
    bus.floor_btn_raw = '0;
    tick(3);

    bus.floor  = 3'd0;
    bus.status = 4'(MOVE_UP);
    press(8'h00, 8'h00, 8'h04);
    check("repeat_set", bus.floor_btn, 8'h04);
    press(8'h00, 8'h00, 8'h04);
`ifdef CALL_CANCEL_EN
    check("cancel_off", bus.floor_btn, 8'h00);
    press(8'h00, 8'h00, 8'h01);
    check("cancel_here_set", bus.floor_btn, 8'h01);
    press(8'h00, 8'h00, 8'h01);
    check("cancel_here_keep", bus.floor_btn, 8'h01);
`else
    check("repeat_keep", bus.floor_btn, 8'h04);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
